// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds the instruction for decode and redirects on PCSrc/PCTarget.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_accept,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] retired,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0] CODE_MISALIGN = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         retired_q, retired_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          code_q, code_d;
    logic                req_q, valid_q, fault_q;
    logic [31:0]         target_c;

    // State and datapath registers; status flags mirror the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            wait_q    <= '0;
            code_q    <= CODE_NONE;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            code_q    <= code_d;
            req_q     <= (state_d == REQ);
            valid_q   <= (state_d == VALID);
            fault_q   <= (state_d == FAULT);
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        code_d    = code_q;
        target_c  = PCSrc ? PCTarget : (pc_q + 32'd4);
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                    state_d = VALID;
                end else if (wait_q == WAIT_LAST) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            VALID: begin
                if (instr_accept) begin
                    // Only a taken redirect can be misaligned; sequential wrap is legal
                    if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                        code_d  = CODE_MISALIGN;
                        state_d = FAULT;
                    end else begin
                        pc_d      = target_c;
                        retired_d = retired_q + 32'd1;
                        state_d   = REQ;
                    end
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign retired     = retired_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the main/ALU decoder controller. It owns the PC and issues word requests to an instruction memory over a req/ack handshake. It holds the returned instruction in an instruction register and presents the op, funct3 and funct7b5 fields plus the full word to decode. It consumes PCSrc/PCTarget from the controller/datapath to select the next PC, and detects fetch timeouts and misaligned redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
MAX_WAIT, 16, maximum REQ cycles without imem_ack before a timeout fault (2..255).

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
imem_req  out  1  fetch request, high only in REQ
imem_addr  out  32  fetch address, equals pc
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word, sampled only when imem_req & imem_ack
instr_valid  out  1  instr and its fields are valid for decode
instr_accept  in  1  downstream has executed the held instruction; PCSrc/PCTarget are valid this cycle
instr  out  32  instruction register
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7b5  out  1  instr[30]
pc  out  32  address of the held or requested instruction
pc_plus4  out  32  pc + 4, modulo 2^32
PCSrc  in  1  take PCTarget as next PC
PCTarget  in  32  branch/jump target
retired  out  32  count of accepted instructions
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 fetch timeout, 10 misaligned target

Behaviour:
- State machine: IDLE, REQ, VALID, FAULT. All state is registered. Outputs decode from state and registers only (no input-to-output combinational paths).
- Reset (reset_n=0 at a clk edge) applies regardless of current state:
  - state=IDLE, pc=RESET_PC, instr=0 (so op/funct3/funct7b5=0), retired=0, wait counter=0, fault=0, fault_code=00.
  - Consequently imem_req=0 and instr_valid=0.
  - A reset mid-request or mid-VALID abandons the transaction; a late imem_ack is ignored.
- IDLE: always goes to REQ on the next cycle. One dead cycle after reset release.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, wait counter<=0, go to VALID.
  - Otherwise the wait counter increments. If the counter equals MAX_WAIT-1 with no ack, go to FAULT with fault_code=01. Timeout therefore occurs after exactly MAX_WAIT unacked REQ cycles; an ack on the MAX_WAIT-th cycle wins.
- VALID:
  - instr_valid=1. Fields are stable until accept.
  - On instr_accept with target = PCSrc ? PCTarget : pc_plus4:
    - If PCSrc=1 and PCTarget[1:0]!=0: go to FAULT with fault_code=10. pc is unchanged and retired is unchanged.
    - Otherwise: pc<=target, retired<=retired+1 (wraps at 2^32), go to REQ.
  - PCSrc and PCTarget are ignored without instr_accept.
- FAULT:
  - imem_req=0, instr_valid=0, fault=1.
  - pc, instr and retired hold their values for debug.
  - Exit only via reset.
- imem_ack outside REQ is ignored.
- Best-case throughput: 1 instruction per 2 cycles (REQ with immediate ack, then VALID with immediate accept).
- pc_plus4 wraps: pc=32'hFFFF_FFFC gives pc_plus4=0. Sequential wrap is legal, not a fault.

Test Plan:
- Reset then zero-wait memory returning 32'h00500093 at 0 and 32'h00000063 at 4, accept every VALID:
  - imem_req first high 1 cycle after reset release; imem_addr 0 then 4.
  - At the first VALID: op=7'h13, funct3=0, funct7b5=0.
  - retired=2 after two accepts.
- Branch redirect: at VALID pc=8, accept with PCSrc=1, PCTarget=32'h40 -> next imem_addr=32'h40, retired increments. Repeat with PCSrc=0 -> imem_addr=12.
- Misaligned target: accept with PCSrc=1, PCTarget=32'h42 -> fault=1, fault_code=10, pc unchanged, imem_req stays 0 for 20 cycles.
- Timeout, MAX_WAIT=16:
  - ack withheld -> FAULT with code 01 after exactly 16 REQ cycles.
  - Separate run with ack on the 16th REQ cycle -> VALID, no fault.
- Reset mid-operation: assert reset_n=0 during REQ, and separately during VALID, with ack arriving in the reset cycle -> pc=RESET_PC, instr=0, retired=0, instr_valid=0. Next fetch at RESET_PC.
- Stall hold and wrap:
  - Hold instr_accept=0 for 10 cycles in VALID -> instr/op/pc unchanged, imem_req=0.
  - With RESET_PC=32'hFFFF_FFFC, accept with PCSrc=0 -> next imem_addr=0.
